// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the packed BCD vector for a given digit count.
    function automatic int bcd_w(input int digits);
        return 4 * digits;
    endfunction

    // Bit counter width: enough to hold BIN_W-1, never narrower than one bit.
    function automatic int cnt_w(input int bin_w);
        return ($clog2(bin_w) < 1) ? 1 : $clog2(bin_w);
    endfunction

    // 10**digits, used to prove the BCD field can hold the largest binary value.
    function automatic longint pow10(input int digits);
        longint acc;
        acc = 64'd1;
        for (int i = 0; i < digits; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_w(8);

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Double-dabble add-3 correction for a single BCD digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 when the digit would overflow past 9 after the next left shift.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Bit-serial double-dabble converter: one input bit per clock, start/busy/done
// handshake, outputs update atomically when the final bit has been shifted in.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BIN_W-1:0]               bin,
    output logic                           busy,
    output logic                           done,
    output logic [bcd_w(DIGITS)-1:0]       bcd,
    output logic [$clog2(DIGITS+1)-1:0]    ndig
);

    localparam int     SW        = bcd_w(DIGITS);
    localparam int     CW        = cnt_w(BIN_W);
    localparam int     NW        = $clog2(DIGITS + 1);
    localparam longint DEC_RANGE = pow10(DIGITS);
    localparam longint BIN_MAX   = (longint'(1) << BIN_W) - 64'd1;

    // The decimal field must be able to represent every binary input value.
    if (DEC_RANGE <= BIN_MAX) begin : g_range_err
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    state_t          state_r;
    state_t          state_nxt_s;
    logic [BIN_W-1:0] shift_r;
    logic [SW-1:0]   scratch_r;
    logic [SW-1:0]   adj_s;
    logic [SW-1:0]   scr_shift_s;
    logic [CW-1:0]   cnt_r;
    logic            load_s;
    logic            step_s;
    logic            last_s;
    logic [NW-1:0]   ndig_nxt_s;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // Scratch after this edge's adjust-and-shift; the shift register MSB enters bit 0.
    assign scr_shift_s = {adj_s[SW-2:0], shift_r[BIN_W-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: accept start only in IDLE, leave SHIFT after the last bit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(0)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM control decode for the datapath.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        last_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start;
            end
            SHIFT: begin
                step_s = 1'b1;
                last_s = (cnt_r == CW'(0));
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Leading-zero priority encoder on the final result; an all-zero value counts as one digit.
    always_comb begin
        ndig_nxt_s = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_shift_s[4*i +: 4] != 4'd0) begin
                ndig_nxt_s = NW'(i + 1);
            end else begin
                ndig_nxt_s = ndig_nxt_s;
            end
        end
    end

    // Datapath: capture, shift one bit per edge, publish result and done on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            ndig      <= NW'(1);
        end else begin
            done <= 1'b0;
            if (load_s) begin
                shift_r   <= bin;
                scratch_r <= '0;
                cnt_r     <= CW'(BIN_W - 1);
                busy      <= 1'b1;
            end else if (step_s) begin
                shift_r   <= shift_r << 1;
                scratch_r <= scr_shift_s;
                if (last_s) begin
                    bcd  <= scr_shift_s;
                    ndig <= ndig_nxt_s;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    cnt_r <= cnt_r - CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter: takes an unsigned binary value (the switch byte) and produces packed BCD digits plus a significant-digit count.
- Sits directly upstream of the seven-segment decode/scan stage, which consumes the BCD and uses the digit count for leading-zero blanking.
- Converts one bit per clock under a start/busy/done handshake.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Elaboration-time check: 10**DIGITS > 2**BIN_W - 1, else $error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request conversion of bin; sampled only when not busy
- bin  in  BIN_W  unsigned value, captured on the accepted start edge
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: bcd and ndig updated this cycle
- bcd  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; holds last result
- ndig  out  $clog2(DIGITS+1)  significant digits, 1..DIGITS (value 0 gives 1)

Behaviour:
- Single clock domain. Only rst is synchronous. rst has priority over all other inputs.
- Reset values: busy=0, done=0, bcd=0, ndig=1, state=IDLE, internal shift/scratch/counter registers=0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - start=1 at edge k: bin is latched into the shift register, the BCD scratch is cleared, the counter is set to BIN_W-1, state goes to SHIFT, busy=1 after edge k.
  - start=0: stay in IDLE.
- SHIFT, one edge per bit (edges k+1 .. k+BIN_W), in this order:
  - For each scratch digit >= 5, add 3 (add-3 adjust).
  - Shift {scratch, shift_reg} left by 1. The MSB of shift_reg enters scratch bit 0.
  - Decrement the counter.
- Final SHIFT edge (counter==0, edge k+BIN_W):
  - bcd <= shifted scratch. No adjust after the last shift.
  - ndig <= index of the highest non-zero digit + 1, or 1 if all digits are zero.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high for exactly the cycle after edge k+BIN_W, i.e. BIN_W clocks after start is accepted.
- start while busy=1 is ignored and not queued. bin changes while busy have no effect.
- start=1 in the done cycle is accepted, because state is already IDLE. This allows back-to-back conversions every BIN_W+1 clocks.
- done is deasserted on every edge except the final SHIFT edge.
- bcd and ndig change only together, on the edge that raises done. They never show partial results.
- rst mid-conversion: the conversion is aborted and all outputs return to their reset values on that edge. No done pulse follows.
- Width rules:
  - Scratch is 4*DIGITS bits. Each digit is adjusted independently with 4-bit arithmetic; the carry-out is impossible because input is < 10.
  - The counter is $clog2(BIN_W) bits wide, minimum 1.

Decomposition:
- Package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT};
  - function bcd_w(DIGITS)=4*DIGITS;
  - localparam for the counter width helper.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 if input >= 5. Instantiated DIGITS times via generate.
- The FSM, shift register, counter and ndig priority encoder stay in bin2bcd_seq.

Test Plan:
- Reset, then start with bin=0 -> 8 clocks later done=1 for exactly 1 cycle, bcd=12'h000, ndig=1, busy=0.
- Convert in sequence 1, 5, 35, 45, 32, 99, 100, 120 -> bcd = 12'h001, 12'h005, 12'h035, 12'h045, 12'h032, 12'h099, 12'h100, 12'h120; ndig = 1, 1, 2, 2, 2, 2, 3, 3.
- bin=255 -> bcd=12'h255, ndig=3. Also sweep all 0..255 against a reference model: every result matches and latency is always 8 clocks.
- start=1 held every cycle, bin=35 then changed to 99 during busy -> only the first conversion runs (bcd=12'h035). Next acceptance is in the done cycle, the second result is 12'h099, and done pulses are spaced 9 clocks apart.
- Convert 120, then rst=1 at shift cycle 4 -> busy=0, bcd=0, ndig=1 next cycle, and no done pulse appears afterwards.
- Parameter build BIN_W=10, DIGITS=4, bin=1023 -> bcd=16'h1023, ndig=4 after 10 clocks. A build with BIN_W=10, DIGITS=3 fails elaboration.
